// File: rtl/tawas_rcn_pkg.sv
// Shared definitions for RCN ring endpoints: packet field positions,
// packet width, the responder FSM states and the ring register mux select.
package tawas_rcn_pkg;

    localparam int PKT_W    = 67;

    localparam int VLD_BIT  = 66;
    localparam int RSP_BIT  = 65;
    localparam int WR_BIT   = 64;
    localparam int ID_MSB   = 63;
    localparam int ID_LSB   = 58;
    localparam int SEQ_MSB  = 57;
    localparam int SEQ_LSB  = 56;
    localparam int MASK_MSB = 55;
    localparam int MASK_LSB = 52;
    localparam int ADDR_MSB = 51;
    localparam int ADDR_LSB = 32;
    localparam int DATA_MSB = 31;
    localparam int DATA_LSB = 0;

    // Responder FSM states
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACCESS   = 2'd1,
        ST_CAPTURE  = 2'd2,
        ST_RSP_PEND = 2'd3
    } slave_state_t;

    // What the ring register loads next cycle
    typedef enum logic [1:0] {
        FWD_PASS   = 2'd0,
        FWD_EMPTY  = 2'd1,
        FWD_INSERT = 2'd2
    } fwd_sel_t;

endpackage

// File: rtl/tawas_rcn_fwd.sv
// Single-stage RCN ring register. Each cycle the slot either passes the
// incoming packet through, is emptied (packet consumed locally), or is
// loaded with a packet inserted by the endpoint.
module tawas_rcn_fwd
    import tawas_rcn_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] ring_in,
    input  fwd_sel_t         sel,
    input  logic [PKT_W-1:0] ins_pkt,
    output logic [PKT_W-1:0] ring_out
);

    logic [PKT_W-1:0] ring_d;
    logic [PKT_W-1:0] ring_q;

    // Choose the next slot content from forward / empty / insert
    always_comb begin
        ring_d = ring_in;
        case (sel)
            FWD_PASS:   ring_d = ring_in;
            FWD_EMPTY:  ring_d = '0;
            FWD_INSERT: ring_d = ins_pkt;
            default:    ring_d = ring_in;
        endcase
    end

    // Ring slot register, cleared by the active-low async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ring_q <= '0;
        end else begin
            ring_q <= ring_d;
        end
    end

    assign ring_out = ring_q;

endmodule

// File: rtl/tawas_rcn_slave.sv
// RCN ring responder. Claims request packets whose word address hits the
// (ADDR_MASK, ADDR_BASE) window, performs the access on a local SRAM-style
// bus and reinserts a response into the first empty ring slot. Only one
// access is outstanding; hits arriving while busy circulate and retry.
// Optional build macro TAWAS_RCN_SLAVE_ACK_EN adds an ack input that
// stretches the local access until the target completes.
module tawas_rcn_slave
    import tawas_rcn_pkg::*;
#(
    parameter logic [19:0] ADDR_MASK = 20'hF_0000,
    parameter logic [19:0] ADDR_BASE = 20'h1_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] rcn_in,
    output logic [PKT_W-1:0] rcn_out,
    output logic             cs,
    output logic             wr,
    output logic [19:0]      addr,
    output logic [3:0]       mask,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata
`ifdef TAWAS_RCN_SLAVE_ACK_EN
    ,
    input  logic             ack
`endif
);

    slave_state_t state_d, state_q;
    logic         cs_d, cs_q;
    logic         wr_d, wr_q;
    logic [19:0]  addr_d, addr_q;
    logic [3:0]   mask_d, mask_q;
    logic [31:0]  wdata_d, wdata_q;
    logic [5:0]   id_d, id_q;
    logic [1:0]   seq_d, seq_q;
    logic [31:0]  rsp_data_d, rsp_data_q;

    logic         in_vld;
    logic         in_rsp;
    logic         in_hit;
    logic         claim;
    logic [31:0]  capture_data;
    logic [31:0]  ins_data;
    logic [PKT_W-1:0] ins_pkt;
    fwd_sel_t     fwd_sel;

    assign in_vld = rcn_in[VLD_BIT];
    assign in_rsp = rcn_in[RSP_BIT];
    assign in_hit = (rcn_in[ADDR_MSB:ADDR_LSB] & ADDR_MASK) == ADDR_BASE;
    assign claim  = in_vld && !in_rsp && in_hit && (state_q == ST_IDLE);

    // Reads return target data, writes echo the written word
    assign capture_data = wr_q ? wdata_q : rdata;

    // In CAPTURE the response can go out straight from rdata so the
    // minimum latency is kept; otherwise it comes from the held register
    assign ins_data = (state_q == ST_CAPTURE) ? capture_data : rsp_data_q;
    assign ins_pkt  = {1'b1, 1'b1, wr_q, id_q, seq_q, mask_q, addr_q, ins_data};

    // Claim / access / response FSM and ring slot selection
    always_comb begin
        state_d    = state_q;
        cs_d       = cs_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        mask_d     = mask_q;
        wdata_d    = wdata_q;
        id_d       = id_q;
        seq_d      = seq_q;
        rsp_data_d = rsp_data_q;
        fwd_sel    = FWD_PASS;

        case (state_q)
            ST_IDLE: begin
                if (claim) begin
                    state_d = ST_ACCESS;
                    cs_d    = 1'b1;
                    wr_d    = rcn_in[WR_BIT];
                    id_d    = rcn_in[ID_MSB:ID_LSB];
                    seq_d   = rcn_in[SEQ_MSB:SEQ_LSB];
                    mask_d  = rcn_in[MASK_MSB:MASK_LSB];
                    addr_d  = rcn_in[ADDR_MSB:ADDR_LSB];
                    wdata_d = rcn_in[DATA_MSB:DATA_LSB];
                    fwd_sel = FWD_EMPTY;
                end
            end
            ST_ACCESS: begin
`ifdef TAWAS_RCN_SLAVE_ACK_EN
                if (ack) begin
                    cs_d       = 1'b0;
                    rsp_data_d = capture_data;
                    state_d    = ST_RSP_PEND;
                end
`else
                cs_d    = 1'b0;
                state_d = ST_CAPTURE;
`endif
            end
            ST_CAPTURE: begin
                if (!in_vld) begin
                    fwd_sel = FWD_INSERT;
                    state_d = ST_IDLE;
                end else begin
                    rsp_data_d = capture_data;
                    state_d    = ST_RSP_PEND;
                end
            end
            ST_RSP_PEND: begin
                if (!in_vld) begin
                    fwd_sel = FWD_INSERT;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, local bus outputs and captured header/response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cs_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            mask_q     <= '0;
            wdata_q    <= '0;
            id_q       <= '0;
            seq_q      <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cs_q       <= cs_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            mask_q     <= mask_d;
            wdata_q    <= wdata_d;
            id_q       <= id_d;
            seq_q      <= seq_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    tawas_rcn_fwd u_fwd (
        .clk      (clk),
        .rst      (rst),
        .ring_in  (rcn_in),
        .sel      (fwd_sel),
        .ins_pkt  (ins_pkt),
        .ring_out (rcn_out)
    );

    assign cs    = cs_q;
    assign wr    = wr_q;
    assign addr  = addr_q;
    assign mask  = mask_q;
    assign wdata = wdata_q;

endmodule

// File: tb/tb_tawas_rcn_slave.sv
// Testbench for tawas_rcn_slave: directed ring scenarios followed by random
// ring traffic, checked against a cycle-numbered reference model that tracks
// the one outstanding request, when its response becomes ready and which
// slot it can occupy. A behavioural SRAM answers the local bus.
// Honours TAWAS_RCN_SLAVE_ACK_EN (random ack delays).
module tb_tawas_rcn_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic [66:0] rcn_in;
    logic [66:0] rcn_out;
    logic        cs;
    logic        wr;
    logic [19:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
`ifdef TAWAS_RCN_SLAVE_ACK_EN
    logic        ack;
`endif

    always #5 clk = ~clk;

    tawas_rcn_slave dut (
        .clk     (clk),
        .rst     (rst),
        .rcn_in  (rcn_in),
        .rcn_out (rcn_out),
        .cs      (cs),
        .wr      (wr),
        .addr    (addr),
        .mask    (mask),
        .wdata   (wdata),
        .rdata   (rdata)
`ifdef TAWAS_RCN_SLAVE_ACK_EN
        ,
        .ack     (ack)
`endif
    );

    int vectors;
    int miscompares;

    // Local target memory and the model's own view of it
    logic [31:0] sram    [256];
    logic [31:0] ref_mem [256];

    // Reference model state
    int          cyc;
    bit          busy;
    logic [66:0] rec;
    logic [31:0] rsp_data;
    int          ready_cycle;
    int          cs_start;
    int          cs_end;
    int          delay;
    logic [66:0] exp_out;

    // Base-build responder pipeline
    logic        prev_rd;
    logic [7:0]  prev_a;

    task automatic checkOutput(input string tag, input logic [66:0] got, input logic [66:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [66:0] mkPkt(input logic vld, input logic rsp, input logic w,
                                          input logic [5:0] id, input logic [1:0] seq,
                                          input logic [3:0] m, input logic [19:0] a,
                                          input logic [31:0] d);
        return {vld, rsp, w, id, seq, m, a, d};
    endfunction

    function automatic logic [31:0] mergeBytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++)
            if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    function automatic logic [66:0] randPkt();
        int          r;
        logic [19:0] a;
        r = $urandom_range(0, 99);
        if (r < 35)
            return {1'b0, 2'($urandom), $urandom, $urandom};
        if (r >= 70 && r < 88)
            a = {4'($urandom_range(2, 15)), 16'($urandom)};
        else
            a = {4'h1, 16'($urandom)};
        return mkPkt(1'b1, r >= 88, 1'($urandom), 6'($urandom), 2'($urandom),
                     4'($urandom), a, $urandom);
    endfunction

    // One clock: check outputs, answer the local bus, drive the ring, advance the model
    task automatic applyStimulus(input logic [66:0] pkt);
        bit   exp_cs;
        bit   hit;
        logic [7:0] idx;
        @(posedge clk);
        #1;
        cyc++;

        checkOutput("rcn_out", rcn_out, exp_out);
        exp_cs = (cyc >= cs_start) && (cyc <= cs_end);
        checkOutput("cs", 67'(cs), 67'(exp_cs));
        if (exp_cs) begin
            checkOutput("wr", 67'(wr), 67'(rec[64]));
            checkOutput("addr", 67'(addr), 67'(rec[51:32]));
            checkOutput("mask", 67'(mask), 67'(rec[55:52]));
            checkOutput("wdata", 67'(wdata), 67'(rec[31:0]));
        end

`ifdef TAWAS_RCN_SLAVE_ACK_EN
        ack   = cs && (cyc == cs_end);
        rdata = sram[addr[7:0]];
        if (ack && wr) sram[addr[7:0]] = mergeBytes(sram[addr[7:0]], wdata, mask);
`else
        rdata = prev_rd ? sram[prev_a] : $urandom;
        if (cs && wr) sram[addr[7:0]] = mergeBytes(sram[addr[7:0]], wdata, mask);
        prev_rd = cs && !wr;
        prev_a  = addr[7:0];
`endif

        rcn_in = pkt;

        hit = (pkt[51:32] & 20'hF_0000) == 20'h1_0000;
        if (pkt[66] && !pkt[65] && hit && !busy) begin
            busy = 1'b1;
            rec  = pkt;
`ifdef TAWAS_RCN_SLAVE_ACK_EN
            delay = $urandom_range(0, 3);
`else
            delay = 0;
`endif
            cs_start    = cyc + 1;
            cs_end      = cyc + 1 + delay;
            ready_cycle = cyc + 2 + delay;
            idx = pkt[39:32];
            if (pkt[64]) begin
                rsp_data     = pkt[31:0];
                ref_mem[idx] = mergeBytes(ref_mem[idx], pkt[31:0], pkt[55:52]);
            end else begin
                rsp_data = ref_mem[idx];
            end
            exp_out = '0;
        end else if (busy && cyc >= ready_cycle && !pkt[66]) begin
            exp_out = mkPkt(1'b1, 1'b1, rec[64], rec[63:58], rec[57:56], rec[55:52],
                            rec[51:32], rsp_data);
            busy = 1'b0;
        end else begin
            exp_out = pkt;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        busy        = 1'b0;
        rec         = '0;
        rsp_data    = '0;
        ready_cycle = 0;
        cs_start    = -10;
        cs_end      = -10;
        delay       = 0;
        exp_out     = '0;
        prev_rd     = 1'b0;
        prev_a      = '0;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = $urandom;
            ref_mem[i] = sram[i];
        end
        sram[4]    = 32'h1234_5678;
        ref_mem[4] = 32'h1234_5678;

        rst    = 1'b0;
        rcn_in = '0;
        rdata  = '0;
`ifdef TAWAS_RCN_SLAVE_ACK_EN
        ack    = 1'b0;
`endif
        #2;
        checkOutput("reset_rcn_out", rcn_out, 67'd0);
        checkOutput("reset_cs", 67'(cs), 67'd0);
        checkOutput("reset_wr", 67'(wr), 67'd0);
        checkOutput("reset_addr", 67'(addr), 67'd0);
        checkOutput("reset_mask", 67'(mask), 67'd0);
        checkOutput("reset_wdata", 67'(wdata), 67'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Pass-through of a non-hit request
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b0, 6'h2A, 2'd1, 4'hF, 20'h2_0040, 32'hDEAD_BEEF));
        applyStimulus('0);
        // Read hit on an idle ring
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b0, 6'h05, 2'd2, 4'hF, 20'h1_0004, 32'h0));
        repeat (6) applyStimulus('0);
        // Write hit, busy retry, then four occupied slots before an empty one
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b1, 6'h09, 2'd3, 4'b0011, 20'h1_0008, 32'hA5A5_0F0F));
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b0, 6'h0C, 2'd0, 4'hF, 20'h1_0010, 32'h1111_2222));
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b0, 6'h01, 2'd0, 4'hF, 20'h3_0000, 32'h0000_0001));
        applyStimulus(mkPkt(1'b1, 1'b1, 1'b0, 6'h02, 2'd1, 4'hF, 20'h1_0020, 32'h0000_0002));
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b1, 6'h03, 2'd2, 4'hF, 20'h4_0000, 32'h0000_0003));
        applyStimulus(mkPkt(1'b1, 1'b1, 1'b1, 6'h04, 2'd3, 4'hF, 20'h5_0000, 32'h0000_0004));
        repeat (8) applyStimulus('0);

        // Random ring traffic
        for (int n = 0; n < 1500; n++)
            applyStimulus(randPkt());

        // Let any outstanding response drain before the reset scenario
        for (int n = 0; n < 40 && busy; n++)
            applyStimulus('0);

        // Reset while the access is in progress
        applyStimulus(mkPkt(1'b1, 1'b0, 1'b0, 6'h11, 2'd1, 4'hF, 20'h1_0010, 32'h0));
        @(posedge clk);
        #1;
        cyc++;
        rcn_in = '0;
        checkOutput("rst_pre_cs", 67'(cs), 67'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("rst_cs", 67'(cs), 67'd0);
        checkOutput("rst_rcn_out", rcn_out, 67'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst      = 1'b1;
        busy     = 1'b0;
        exp_out  = '0;
        cs_start = -10;
        cs_end   = -10;
        prev_rd  = 1'b0;
        repeat (8) applyStimulus('0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
